lcd_spi_rx: RTL
===============

// Module: lcd_spi_rx
// PURPOSE
//  Display-side receiver for the 4-wire LCD serial bus (cs/rs/data, 1 bit per clk, MSB first).
//  Deframes bytes, decodes ST7789-style commands (SLPIN/SLPOUT/DISPOFF/DISPON/CASET/RASET/RAMWR),
//  and emits one pixel strobe with coordinates per 16-bit RAMWR pixel.
//  Sits beside the LCD driver as a bus monitor and scoreboard source; shares the driver's clk.
// PARAMETERS
//  XE_RST  239  column-window end after reset (column start resets to 0)
//  YE_RST  134  row-window end after reset (row start resets to 0)
// PORTS
//  clk         in   1   system clock; bus bits sampled on posedge
//  resetn      in   1   asynchronous active-low reset
//  lcd_resetn  in   1   panel reset line; low = synchronous soft reset of all decoder state
//  lcd_cs      in   1   chip select, active low; a bit is sampled every clk while low
//  lcd_rs      in   1   0 = command byte, 1 = data byte; sampled with bit 7 of each byte
//  lcd_data    in   1   serial data, MSB first
//  cmd_valid   out  1   1-cycle strobe: command byte received
//  cmd_code    out  8   last command byte; holds until next command
//  pix_valid   out  1   1-cycle strobe: RAMWR pixel completed
//  pix_data    out  16  RGB565 pixel (first byte = [15:8])
//  pix_x       out  16  column of pix_data
//  pix_y       out  16  row of pix_data
//  frame_done  out  1   1-cycle strobe, coincident with pix_valid of pixel at (xe,ye)
//  sleeping    out  1   1 after reset; 0x11 clears, 0x10 sets
//  disp_on     out  1   0 after reset; 0x29 sets, 0x28 clears
//  err         out  1   sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (resetn low, or lcd_resetn low at a clk edge): all strobes 0, cmd_code=0, pix_*=0,
//    sleeping=1, disp_on=0, err=0, window xs=0 xe=XE_RST ys=0 ye=YE_RST, opcode=0, counters 0.
//  - Deframer: 3-bit bit counter + 8-bit shift reg advance on each posedge with lcd_cs=0;
//    lcd_rs latched when counter=0. Counter clears whenever lcd_cs=1 (partial byte discarded).
//    cs may stay low across several bytes (pixel = 16 continuous bits) or rise between bytes.
//  - All outputs registered; strobes are visible the cycle after the edge sampling bit 0.
//  - Command byte (rs=0): cmd_valid=1, cmd_code=byte, opcode=byte, param index=0,
//    pixel byte phase=0; pending partial CASET/RASET params discarded.
//    0x2C additionally sets write pointer (px,py)=(xs,ys).
//  - Data byte (rs=1) by opcode:
//    0x2A: params 0..3 = xs_hi,xs_lo,xe_hi,xe_lo; xs/xe both updated only on param 3; extra ignored.
//    0x2B: same for ys/ye.
//    0x2C: phase 0 stores high byte; phase 1 emits pix_valid, pix_data, pix_x=px, pix_y=py, then
//          advance: px==xe -> px=xs and (py==ye ? py=ys : py=py+1); else px=px+1 (16-bit wrap).
//          frame_done=1 when px==xe && py==ye on that pixel. Pixel bytes may span cs frames.
//    other: data ignored (param index still counts).
//  - xs>xe or ys>ye: no special case; pointer increments with 16-bit wrap until equality.
//  - cmd_valid and pix_valid never assert in the same cycle (one byte completes per 8 clks).
// CONFIGURATION
//  LCD_RX_ERR_EN defined: err set (sticky until reset) when
//    (a) lcd_cs rises with bit counter != 0, (b) data byte arrives while opcode=0,
//    (c) 0x2C data or any command arrives while sleeping=1 except 0x11 and 0x01.
//  LCD_RX_ERR_EN undefined: no checker logic; err tied to 0.
// TESTING
//  1 reset: resetn 0->1, idle cs=1 -> all outputs at reset values, sleeping=1, err=0.
//  2 cmd 0x11 then 0x29 (cs frame each) -> two cmd_valid pulses, codes 11/29, sleeping=0 disp_on=1.
//  3 CASET 00 28 01 17, RASET 00 35 00 BB, RAMWR, pixels F800,07E0 -> pix (0x28,0x35)=F800,
//    (0x29,0x35)=07E0; each pix_valid exactly 17 clks after cs falls for 16-bit frames.
//  4 window 2x2 (CASET 0..1, RASET 0..1), RAMWR, 5 pixels -> coords (0,0)(1,0)(0,1)(1,1)(0,0);
//    frame_done only on 4th pixel.
//  5 cs high after 5 bits of RAMWR data, then full pixel AAAA -> partial ignored, pix_data=AAAA;
//    with LCD_RX_ERR_EN err=1, without err=0.
//  6 lcd_resetn pulsed low mid-pixel -> state back to reset values; next RAMWR starts at (0,0).

Source files
------------

// File: rtl/lcd_spi_rx.sv
// Display-side receiver for the 4-wire LCD serial bus: deframes bytes, decodes ST7789-style commands, emits RAMWR pixels.
// Optional protocol checker enabled by defining LCD_RX_ERR_EN; otherwise err is tied low.
module lcd_spi_rx #(
   parameter logic [15:0] XE_RST = 16'd239,
   parameter logic [15:0] YE_RST = 16'd134
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        lcd_resetn,
   input  logic        lcd_cs,
   input  logic        lcd_rs,
   input  logic        lcd_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic        frame_done,
   output logic        sleeping,
   output logic        disp_on,
   output logic        err
);

   typedef enum logic {PH_HI, PH_LO} phase_e;

   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shreg_q, shreg_d;
   logic        rs_q, rs_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [2:0]  pidx_q, pidx_d;
   logic [7:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
   logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [15:0] px_q, px_d, py_q, py_d;
   phase_e      phase_q, phase_d;
   logic [7:0]  hi_q, hi_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_code_q, cmd_code_d;
   logic        pix_valid_q, pix_valid_d;
   logic [15:0] pix_data_q, pix_data_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic        frame_done_q, frame_done_d;
   logic        sleeping_q, sleeping_d;
   logic        disp_on_q, disp_on_d;
   logic [7:0]  byte_w;
`ifdef LCD_RX_ERR_EN
   logic        err_q, err_d;
`endif

   assign byte_w = {shreg_q, lcd_data};

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      rs_d         = rs_q;
      opcode_d     = opcode_q;
      pidx_d       = pidx_q;
      p0_d         = p0_q;
      p1_d         = p1_q;
      p2_d         = p2_q;
      xs_d         = xs_q;
      xe_d         = xe_q;
      ys_d         = ys_q;
      ye_d         = ye_q;
      px_d         = px_q;
      py_d         = py_q;
      phase_d      = phase_q;
      hi_d         = hi_q;
      cmd_valid_d  = 1'b0;
      cmd_code_d   = cmd_code_q;
      pix_valid_d  = 1'b0;
      pix_data_d   = pix_data_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      frame_done_d = 1'b0;
      sleeping_d   = sleeping_q;
      disp_on_d    = disp_on_q;
`ifdef LCD_RX_ERR_EN
      err_d        = err_q;
`endif
      if (!lcd_resetn) begin
         bit_cnt_d  = '0;
         shreg_d    = '0;
         rs_d       = 1'b0;
         opcode_d   = '0;
         pidx_d     = '0;
         p0_d       = '0;
         p1_d       = '0;
         p2_d       = '0;
         xs_d       = '0;
         xe_d       = XE_RST;
         ys_d       = '0;
         ye_d       = YE_RST;
         px_d       = '0;
         py_d       = '0;
         phase_d    = PH_HI;
         hi_d       = '0;
         cmd_code_d = '0;
         pix_data_d = '0;
         pix_x_d    = '0;
         pix_y_d    = '0;
         sleeping_d = 1'b1;
         disp_on_d  = 1'b0;
`ifdef LCD_RX_ERR_EN
         err_d      = 1'b0;
`endif
      end else if (lcd_cs) begin
`ifdef LCD_RX_ERR_EN
         if (bit_cnt_q != 3'd0) err_d = 1'b1;
`endif
         bit_cnt_d = '0;
      end else begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         shreg_d   = byte_w[6:0];
         if (bit_cnt_q == 3'd0) rs_d = lcd_rs;
         // rs_q was captured with bit 7 of this same byte
         if (bit_cnt_q == 3'd7) begin
            if (!rs_q) begin
               cmd_valid_d = 1'b1;
               cmd_code_d  = byte_w;
               opcode_d    = byte_w;
               pidx_d      = '0;
               phase_d     = PH_HI;
`ifdef LCD_RX_ERR_EN
               if (sleeping_q && byte_w != 8'h11 && byte_w != 8'h01) err_d = 1'b1;
`endif
               case (byte_w)
                  8'h10: sleeping_d = 1'b1;
                  8'h11: sleeping_d = 1'b0;
                  8'h28: disp_on_d  = 1'b0;
                  8'h29: disp_on_d  = 1'b1;
                  8'h2C: begin
                     px_d = xs_q;
                     py_d = ys_q;
                  end
                  default: ;
               endcase
            end else begin
               if (pidx_q != 3'd4) pidx_d = pidx_q + 3'd1;
`ifdef LCD_RX_ERR_EN
               if (opcode_q == 8'h00) err_d = 1'b1;
               if (opcode_q == 8'h2C && sleeping_q) err_d = 1'b1;
`endif
               case (opcode_q)
                  8'h2A, 8'h2B: begin
                     case (pidx_q)
                        3'd0: p0_d = byte_w;
                        3'd1: p1_d = byte_w;
                        3'd2: p2_d = byte_w;
                        3'd3: begin
                           if (opcode_q == 8'h2A) begin
                              xs_d = {p0_q, p1_q};
                              xe_d = {p2_q, byte_w};
                           end else begin
                              ys_d = {p0_q, p1_q};
                              ye_d = {p2_q, byte_w};
                           end
                        end
                        default: ;
                     endcase
                  end
                  8'h2C: begin
                     if (phase_q == PH_HI) begin
                        hi_d    = byte_w;
                        phase_d = PH_LO;
                     end else begin
                        phase_d      = PH_HI;
                        pix_valid_d  = 1'b1;
                        pix_data_d   = {hi_q, byte_w};
                        pix_x_d      = px_q;
                        pix_y_d      = py_q;
                        frame_done_d = (px_q == xe_q) && (py_q == ye_q);
                        if (px_q == xe_q) begin
                           px_d = xs_q;
                           py_d = (py_q == ye_q) ? ys_q : py_q + 16'd1;
                        end else begin
                           px_d = px_q + 16'd1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         rs_q         <= 1'b0;
         opcode_q     <= '0;
         pidx_q       <= '0;
         p0_q         <= '0;
         p1_q         <= '0;
         p2_q         <= '0;
         xs_q         <= '0;
         xe_q         <= XE_RST;
         ys_q         <= '0;
         ye_q         <= YE_RST;
         px_q         <= '0;
         py_q         <= '0;
         phase_q      <= PH_HI;
         hi_q         <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_code_q   <= '0;
         pix_valid_q  <= 1'b0;
         pix_data_q   <= '0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         frame_done_q <= 1'b0;
         sleeping_q   <= 1'b1;
         disp_on_q    <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         rs_q         <= rs_d;
         opcode_q     <= opcode_d;
         pidx_q       <= pidx_d;
         p0_q         <= p0_d;
         p1_q         <= p1_d;
         p2_q         <= p2_d;
         xs_q         <= xs_d;
         xe_q         <= xe_d;
         ys_q         <= ys_d;
         ye_q         <= ye_d;
         px_q         <= px_d;
         py_q         <= py_d;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_code_q   <= cmd_code_d;
         pix_valid_q  <= pix_valid_d;
         pix_data_q   <= pix_data_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         frame_done_q <= frame_done_d;
         sleeping_q   <= sleeping_d;
         disp_on_q    <= disp_on_d;
      end
   end

`ifdef LCD_RX_ERR_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) err_q <= 1'b0;
      else         err_q <= err_d;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign cmd_valid  = cmd_valid_q;
   assign cmd_code   = cmd_code_q;
   assign pix_valid  = pix_valid_q;
   assign pix_data   = pix_data_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign frame_done = frame_done_q;
   assign sleeping   = sleeping_q;
   assign disp_on    = disp_on_q;

endmodule
